// File: rtl/fractal_sync_cnt_local_rf.sv
// Local barrier counter register file: per-entry arrival counting and thresholds.
// Define FRACTAL_SYNC_CNT_RF_TIMEOUT_EN to add per-entry idle timeouts.
module fractal_sync_cnt_local_rf #(
  parameter int unsigned N_REGS    = 4,
  parameter int unsigned ID_WIDTH  = 3,
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned CNT_WIDTH = 3,
  parameter int unsigned TO_WIDTH  = 8,
  localparam int unsigned IDX_W =
    (N_REGS > 1) ? $clog2(N_REGS) : 1,
  localparam int unsigned SUM_W =
    CNT_WIDTH + $clog2(N_PORTS + 1),
  localparam int unsigned LI_W = ID_WIDTH - 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [N_PORTS-1:0][ID_WIDTH-1:0]   id_i,
  input  logic [N_PORTS-1:0]                 check_i,
  output logic [N_PORTS-1:0]                 present_o,
  output logic [N_PORTS-1:0]                 ignore_o,
  output logic [N_PORTS-1:0]                 id_err_o,
  output logic [N_PORTS-1:0]                 ovf_err_o,
  input  logic                               cfg_we_i,
  input  logic [IDX_W-1:0]                   cfg_idx_i,
  input  logic [CNT_WIDTH-1:0]               cfg_thr_i,
  output logic                               cfg_err_o,
  output logic [N_REGS-1:0]                  busy_o,
  output logic [N_REGS-1:0]                  timeout_o
);

  logic [N_REGS-1:0][CNT_WIDTH-1:0] cnt_q;
  logic [N_REGS-1:0][CNT_WIDTH-1:0] thr_q;
  logic [N_REGS-1:0][CNT_WIDTH-1:0] cnt_d;
  logic [N_REGS-1:0][SUM_W-1:0]     k;
  logic [N_REGS-1:0][SUM_W-1:0]     sum;
  logic [N_REGS-1:0]                busy_q;
  logic [N_REGS-1:0]                fire;
  logic [N_REGS-1:0]                seen;
  logic [N_PORTS-1:0][LI_W-1:0]     lidx;
  logic [N_PORTS-1:0]               vld;
  logic [N_PORTS-1:0]               id_lsb;
  logic                             cfg_ok;
  logic                             cfg_hit;
  logic                             unused_id_lsb;

  always_comb begin
    present_o = '0;
    ignore_o  = '0;
    ovf_err_o = '0;
    seen      = '0;
    cfg_hit   = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      lidx[p]     = id_i[p][ID_WIDTH-1:1];
      id_lsb[p]   = id_i[p][0];
      id_err_o[p] = 32'(lidx[p]) >= 32'(N_REGS);
      vld[p]      = check_i[p] & ~id_err_o[p] & ~rst_i;
    end
    for (int e = 0; e < N_REGS; e++) begin
      k[e] = '0;
      for (int p = 0; p < N_PORTS; p++) begin
        if (vld[p] && 32'(lidx[p]) == 32'(e))
          k[e] = k[e] + SUM_W'(1);
      end
      // a timing-out entry restarts from zero
      sum[e] = (fire[e] ? SUM_W'(0) : SUM_W'(cnt_q[e]))
             + k[e];
      cnt_d[e] = (sum[e] >= SUM_W'(thr_q[e])) ?
                 '0 : sum[e][CNT_WIDTH-1:0];
      for (int p = 0; p < N_PORTS; p++) begin
        if (vld[p] && 32'(lidx[p]) == 32'(e)) begin
          if (sum[e] == SUM_W'(thr_q[e])) begin
            present_o[p] = ~seen[e];
            ignore_o[p]  = seen[e];
          end else if (sum[e] > SUM_W'(thr_q[e])) begin
            ovf_err_o[p] = 1'b1;
          end
          seen[e] = 1'b1;
        end
      end
      if (32'(cfg_idx_i) == 32'(e) &&
          cnt_q[e] == '0 && k[e] == '0)
        cfg_hit = 1'b1;
    end
    cfg_ok = cfg_we_i & cfg_hit & ~rst_i &
             (cfg_thr_i >= CNT_WIDTH'(2));
    cfg_err_o = cfg_we_i & ~cfg_ok & ~rst_i;
  end

  assign unused_id_lsb = ^id_lsb;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      busy_q <= '0;
      for (int e = 0; e < N_REGS; e++)
        thr_q[e] <= CNT_WIDTH'(2);
    end else begin
      for (int e = 0; e < N_REGS; e++) begin
        cnt_q[e]  <= cnt_d[e];
        busy_q[e] <= cnt_d[e] != '0;
        if (cfg_ok && 32'(cfg_idx_i) == 32'(e))
          thr_q[e] <= cfg_thr_i;
      end
    end
  end

  assign busy_o = busy_q & {N_REGS{~rst_i}};

`ifdef FRACTAL_SYNC_CNT_RF_TIMEOUT_EN
  logic [N_REGS-1:0][TO_WIDTH-1:0] to_q;

  always_comb begin
    for (int e = 0; e < N_REGS; e++)
      fire[e] = ~rst_i & (cnt_q[e] != '0) & (&to_q[e]);
  end

  always_ff @(posedge clk_i) begin
    for (int e = 0; e < N_REGS; e++) begin
      if (rst_i || fire[e] || cnt_q[e] == '0 || k[e] != '0)
        to_q[e] <= '0;
      else
        to_q[e] <= to_q[e] + TO_WIDTH'(1);
    end
  end

  assign timeout_o = fire;
`else
  logic [TO_WIDTH-1:0] unused_to;

  assign unused_to = '0;
  assign fire      = '0;
  assign timeout_o = '0;
`endif

endmodule

// File: tb/tb_fractal_sync_cnt_local_rf.sv
// Bench for fractal_sync_cnt_local_rf: per-cycle model compare plus directed checks.
// Set FRACTAL_SYNC_CNT_RF_TIMEOUT_EN to also exercise the timeout path.
module tb_fractal_sync_cnt_local_rf;
  localparam int NR = 4;
  localparam int IW = 4;
  localparam int NP = 4;
  localparam int CW = 3;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0][IW-1:0] id;
  logic [NP-1:0] chk;
  logic [NP-1:0] present_o, ignore_o;
  logic [NP-1:0] id_err_o, ovf_err_o;
  logic cfg_we;
  logic [1:0] cfg_idx;
  logic [CW-1:0] cfg_thr;
  logic cfg_err_o;
  logic [NR-1:0] busy_o, timeout_o;

  int total = 0;
  int bad = 0;

  int m_cnt[NR], m_thr[NR], m_to[NR];
  int n_cnt[NR], n_thr[NR], n_to[NR];
  int li[NP];
  int na[NR];
  int first[NR];
  bit fire_m[NR];
  logic [NP-1:0] ep, ei, eo, ee;
  logic [NR-1:0] eb, et;
  logic ecf;

  fractal_sync_cnt_local_rf #(
    .N_REGS(NR), .ID_WIDTH(IW), .N_PORTS(NP),
    .CNT_WIDTH(CW), .TO_WIDTH(TW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .id_i(id),
    .check_i(chk), .present_o(present_o),
    .ignore_o(ignore_o), .id_err_o(id_err_o),
    .ovf_err_o(ovf_err_o), .cfg_we_i(cfg_we),
    .cfg_idx_i(cfg_idx), .cfg_thr_i(cfg_thr),
    .cfg_err_o(cfg_err_o), .busy_o(busy_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  initial begin
    for (int e = 0; e < NR; e++) begin
      n_cnt[e] = 0; n_thr[e] = 2; n_to[e] = 0;
    end
  end

  // model: outputs from current model state and inputs
  always @(negedge clk) begin
    ep = '0; ei = '0; eo = '0; ee = '0;
    eb = '0; et = '0;
    for (int p = 0; p < NP; p++) begin
      li[p] = int'(id[p]) / 2;
      ee[p] = li[p] >= NR;
    end
    for (int e = 0; e < NR; e++) begin
      int s;
      na[e] = 0; first[e] = -1;
      for (int p = 0; p < NP; p++)
        if (!rst && chk[p] && !ee[p] && li[p] == e) begin
          na[e]++;
          if (first[e] < 0) first[e] = p;
        end
`ifdef FRACTAL_SYNC_CNT_RF_TIMEOUT_EN
      fire_m[e] = !rst && m_cnt[e] != 0 &&
                  m_to[e] == (1 << TW) - 1;
`else
      fire_m[e] = 1'b0;
`endif
      et[e] = fire_m[e];
      eb[e] = !rst && m_cnt[e] != 0;
      s = (fire_m[e] ? 0 : m_cnt[e]) + na[e];
      for (int p = 0; p < NP; p++)
        if (!rst && chk[p] && !ee[p] && li[p] == e) begin
          if (s == m_thr[e]) begin
            if (p == first[e]) ep[p] = 1'b1;
            else ei[p] = 1'b1;
          end else if (s > m_thr[e]) eo[p] = 1'b1;
        end
      n_cnt[e] = (rst || s >= m_thr[e]) ? 0 : s;
      n_thr[e] = rst ? 2 : m_thr[e];
      if (rst || fire_m[e] || m_cnt[e] == 0 || na[e] > 0)
        n_to[e] = 0;
      else
        n_to[e] = m_to[e] + 1;
    end
    ecf = 1'b0;
    if (cfg_we && !rst) begin
      if (m_cnt[cfg_idx] == 0 && na[cfg_idx] == 0 &&
          cfg_thr >= 2)
        n_thr[cfg_idx] = int'(cfg_thr);
      else
        ecf = 1'b1;
    end
    check("m_present", present_o, ep);
    check("m_ignore", ignore_o, ei);
    check("m_ovf", ovf_err_o, eo);
    check("m_iderr", id_err_o, ee);
    check("m_cfgerr", cfg_err_o, ecf);
    check("m_busy", busy_o, eb);
    check("m_timeout", timeout_o, et);
  end

  always @(posedge clk) begin
    for (int e = 0; e < NR; e++) begin
      m_cnt[e] = n_cnt[e];
      m_thr[e] = n_thr[e];
      m_to[e]  = n_to[e];
    end
  end

  task automatic clr();
    chk = '0; id = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_thr = '0;
  endtask

  task automatic go();
    @(negedge clk); #1;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
    clr();
  endtask

  task automatic arr(input int p, input int i);
    chk[p] = 1'b1;
    id[p] = IW'(i);
  endtask

  task automatic cfg(input int e, input int t);
    cfg_we = 1'b1;
    cfg_idx = 2'(e);
    cfg_thr = CW'(t);
  endtask

  initial begin
    clr();
    rst = 1'b1;
    arr(0, 2); arr(1, 2); cfg(0, 5);
    go();
    check("rst_present", present_o, 0);
    check("rst_cfgerr", cfg_err_o, 0);
    check("rst_busy", busy_o, 0);
    nxt(); go(); nxt();
    rst = 1'b0;

    arr(0, 3); arr(2, 3);
    go();
    check("pair_present", present_o, 4'b0001);
    check("pair_ignore", ignore_o, 4'b0100);
    nxt(); go();
    check("pair_busy", busy_o[1], 0);
    nxt();

    cfg(2, 4);
    go(); check("cfg4_err", cfg_err_o, 0);
    nxt();
    for (int c = 0; c <= 6; c++) begin
      if (c == 0) arr(0, 4);
      if (c == 3) begin arr(1, 4); arr(3, 4); end
      if (c == 5) arr(2, 5);
      go();
      check("b4_busy", busy_o[2], (c >= 1 && c <= 5));
      if (c == 5) check("b4_present", present_o, 4'b0100);
      if (c == 3) check("b4_early", present_o, 0);
      nxt();
    end

    cfg(0, 3); go(); nxt();
    arr(0, 0); arr(1, 1); go();
    check("ovf_pre", present_o | ovf_err_o, 0);
    nxt();
    arr(0, 0); arr(1, 0); go();
    check("ovf_err", ovf_err_o, 4'b0011);
    check("ovf_nopres", present_o | ignore_o, 0);
    nxt(); go();
    check("ovf_busy", busy_o[0], 0);
    nxt();

    arr(1, 9); id[3] = IW'(15); go();
    check("iderr", id_err_o, 4'b1010);
    check("iderr_pres", present_o | ovf_err_o, 0);
    nxt(); go();
    check("iderr_busy", busy_o, 0);
    nxt();
    cfg(1, 1); go(); check("cfg_low", cfg_err_o, 1);
    nxt();
    arr(0, 2); go(); nxt();
    cfg(1, 5); go(); check("cfg_busy", cfg_err_o, 1);
    nxt();
    cfg(2, 6); arr(0, 4); go();
    check("cfg_arrive", cfg_err_o, 1);
    nxt();
    arr(1, 3); go();
    check("thr_kept", present_o, 4'b0010);
    nxt();
    arr(0, 4); arr(1, 4); arr(2, 4); go();
    check("thr2_kept_p", present_o, 4'b0001);
    check("thr2_kept_i", ignore_o, 4'b0110);
    nxt();

    cfg(3, 3); go(); nxt();
    arr(0, 6); go(); nxt();
    rst = 1'b1; arr(1, 7); go();
    check("midrst_pres", present_o, 0);
    check("midrst_busy", busy_o, 0);
    nxt();
    rst = 1'b0;
    cfg(3, 3); go(); check("recfg", cfg_err_o, 0);
    nxt();
    arr(0, 7); go(); nxt();
    arr(2, 7); go();
    check("rst_drop", present_o, 0);
    nxt();
    arr(3, 7); go();
    check("rst_third", present_o, 4'b1000);
    nxt();

    cfg(1, 7); go(); check("cfg_max", cfg_err_o, 0);
    nxt();
    for (int p = 0; p < NP; p++) arr(p, 2);
    go(); check("max_part", present_o, 0);
    nxt();
    arr(0, 3); arr(1, 2); arr(3, 3); go();
    check("max_pres", present_o, 4'b0001);
    check("max_ign", ignore_o, 4'b1010);
    nxt();

    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 2) == 0)
          arr(p, $urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0)
        cfg($urandom_range(0, 3), $urandom_range(0, 7));
      go(); nxt();
    end
    rst = 1'b0;

`ifdef FRACTAL_SYNC_CNT_RF_TIMEOUT_EN
    rst = 1'b1; go(); nxt(); rst = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (c == 0) arr(0, 2);
      go();
      check("to_pulse", timeout_o[1], (c == 16));
      check("to_busy", busy_o[1], (c >= 1 && c <= 16));
      nxt();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
